// File: rtl/yzb_denetleyici.sv
// Issue/sequencing controller in front of the AI unit: forwards micro-ops as one-cycle
// pulses, tracks X/W fill levels, and stalls RUN until the unit's dot product is ready.
module yzb_denetleyici #(
    parameter int unsigned VERI_BIT       = 32,
    parameter int unsigned UOP_YZB_BIT    = 3,
    parameter int unsigned N_CNN_YAZMAC   = 16,
    parameter int unsigned CNN_YAZMAC_BIT = 5
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   istek_gecerli_i,
    output logic                   istek_hazir_o,
    input  logic [UOP_YZB_BIT-1:0] istek_kod_i,
    input  logic [VERI_BIT-1:0]    istek_islec1_i,
    input  logic [VERI_BIT-1:0]    istek_islec2_i,
    input  logic [4:0]             istek_rd_i,
    input  logic                   iptal_i,
    output logic [UOP_YZB_BIT-1:0] yzb_kod_o,
    output logic [VERI_BIT-1:0]    yzb_islec1_o,
    output logic [VERI_BIT-1:0]    yzb_islec2_o,
    input  logic [VERI_BIT-1:0]    yzb_sonuc_i,
    input  logic                   yzb_gecerli_i,
    output logic [VERI_BIT-1:0]    sonuc_o,
    output logic [4:0]             sonuc_rd_o,
    output logic                   sonuc_gecerli_o,
    input  logic                   sonuc_hazir_i,
    output logic                   hata_o
);

    // Micro-op encodings, kept in step with mikroislem.vh.
    localparam logic [UOP_YZB_BIT-1:0] UOP_YZB_NOP     = UOP_YZB_BIT'(0);
    localparam logic [UOP_YZB_BIT-1:0] UOP_YZB_LDX_OP1 = UOP_YZB_BIT'(1);
    localparam logic [UOP_YZB_BIT-1:0] UOP_YZB_LDX_ALL = UOP_YZB_BIT'(2);
    localparam logic [UOP_YZB_BIT-1:0] UOP_YZB_LDW_OP1 = UOP_YZB_BIT'(3);
    localparam logic [UOP_YZB_BIT-1:0] UOP_YZB_LDW_ALL = UOP_YZB_BIT'(4);
    localparam logic [UOP_YZB_BIT-1:0] UOP_YZB_CLRX    = UOP_YZB_BIT'(5);
    localparam logic [UOP_YZB_BIT-1:0] UOP_YZB_CLRW    = UOP_YZB_BIT'(6);
    localparam logic [UOP_YZB_BIT-1:0] UOP_YZB_RUN     = UOP_YZB_BIT'(7);

    localparam logic [CNN_YAZMAC_BIT:0] SINIR = (CNN_YAZMAC_BIT + 1)'(N_CNN_YAZMAC);

    typedef enum logic [1:0] {Bosta, Calistir, Yaz} durum_e;

    durum_e                    durum_q, durum_d;
    logic [UOP_YZB_BIT-1:0]    kod_q, kod_d;
    logic [VERI_BIT-1:0]       islec1_q, islec1_d, islec2_q, islec2_d;
    logic [VERI_BIT-1:0]       sonuc_q, sonuc_d;
    logic [4:0]                rd_q, rd_d;
    logic                      hata_q, hata_d;
    logic [CNN_YAZMAC_BIT-1:0] sx_q, sx_d, sw_q, sw_d;
    logic [CNN_YAZMAC_BIT:0]   sx_yeni, sw_yeni;

    // One extra bit so a count of N plus 2 cannot wrap below the limit.
    assign sx_yeni = {1'b0, sx_q} +
                     ((istek_kod_i == UOP_YZB_LDX_ALL) ? (CNN_YAZMAC_BIT + 1)'(2)
                                                       : (CNN_YAZMAC_BIT + 1)'(1));
    assign sw_yeni = {1'b0, sw_q} +
                     ((istek_kod_i == UOP_YZB_LDW_ALL) ? (CNN_YAZMAC_BIT + 1)'(2)
                                                       : (CNN_YAZMAC_BIT + 1)'(1));

    always_comb begin
        durum_d  = durum_q;
        kod_d    = UOP_YZB_NOP;
        islec1_d = islec1_q;
        islec2_d = islec2_q;
        sonuc_d  = sonuc_q;
        rd_d     = rd_q;
        hata_d   = 1'b0;
        sx_d     = sx_q;
        sw_d     = sw_q;
        case (durum_q)
            Bosta: begin
                if (istek_gecerli_i && !iptal_i) begin
                    kod_d    = istek_kod_i;
                    islec1_d = istek_islec1_i;
                    islec2_d = istek_islec2_i;
                    case (istek_kod_i)
                        UOP_YZB_RUN: begin
                            durum_d = Calistir;
                            rd_d    = istek_rd_i;
                        end
                        UOP_YZB_LDX_OP1, UOP_YZB_LDX_ALL: begin
                            if (sx_yeni > SINIR) begin
                                kod_d    = UOP_YZB_NOP;
                                islec1_d = islec1_q;
                                islec2_d = islec2_q;
                                hata_d   = 1'b1;
                            end else begin
                                sx_d = sx_yeni[CNN_YAZMAC_BIT-1:0];
                            end
                        end
                        UOP_YZB_LDW_OP1, UOP_YZB_LDW_ALL: begin
                            if (sw_yeni > SINIR) begin
                                kod_d    = UOP_YZB_NOP;
                                islec1_d = islec1_q;
                                islec2_d = islec2_q;
                                hata_d   = 1'b1;
                            end else begin
                                sw_d = sw_yeni[CNN_YAZMAC_BIT-1:0];
                            end
                        end
                        UOP_YZB_CLRX: sx_d = '0;
                        UOP_YZB_CLRW: sw_d = '0;
                        default: ;
                    endcase
                end
            end
            Calistir: begin
                if (iptal_i) begin
                    durum_d = Bosta;
                end else if (yzb_gecerli_i) begin
                    sonuc_d = yzb_sonuc_i;
                    durum_d = Yaz;
                end else begin
                    kod_d = UOP_YZB_RUN;
                end
            end
            Yaz: begin
                if (iptal_i || sonuc_hazir_i) durum_d = Bosta;
            end
            default: durum_d = Bosta;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            durum_q  <= Bosta;
            kod_q    <= UOP_YZB_NOP;
            islec1_q <= '0;
            islec2_q <= '0;
            sonuc_q  <= '0;
            rd_q     <= '0;
            hata_q   <= 1'b0;
            sx_q     <= '0;
            sw_q     <= '0;
        end else begin
            durum_q  <= durum_d;
            kod_q    <= kod_d;
            islec1_q <= islec1_d;
            islec2_q <= islec2_d;
            sonuc_q  <= sonuc_d;
            rd_q     <= rd_d;
            hata_q   <= hata_d;
            sx_q     <= sx_d;
            sw_q     <= sw_d;
        end
    end

    assign istek_hazir_o   = (durum_q == Bosta);
    assign yzb_kod_o       = kod_q;
    assign yzb_islec1_o    = islec1_q;
    assign yzb_islec2_o    = islec2_q;
    assign sonuc_o         = sonuc_q;
    assign sonuc_rd_o      = rd_q;
    assign sonuc_gecerli_o = (durum_q == Yaz);
    assign hata_o          = hata_q;

endmodule

// File: tb/tb_yzb_denetleyici.sv
// Directed bench for yzb_denetleyici: loads, RUN, overflow, backpressure, flush and reset.
module tb_yzb_denetleyici;

    localparam logic [2:0] NOP = 3'd0, LDX_OP1 = 3'd1, LDX_ALL = 3'd2, LDW_OP1 = 3'd3,
                           LDW_ALL = 3'd4, CLRX = 3'd5, CLRW = 3'd6, RUN = 3'd7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        istek_gecerli = 1'b0;
    logic        istek_hazir;
    logic [2:0]  istek_kod = NOP;
    logic [31:0] istek_islec1 = '0, istek_islec2 = '0;
    logic [4:0]  istek_rd = '0;
    logic        iptal = 1'b0;
    logic [2:0]  yzb_kod;
    logic [31:0] yzb_islec1, yzb_islec2;
    logic [31:0] yzb_sonuc = '0;
    logic        yzb_gecerli = 1'b0;
    logic [31:0] sonuc;
    logic [4:0]  sonuc_rd;
    logic        sonuc_gecerli;
    logic        sonuc_hazir = 1'b0;
    logic        hata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    yzb_denetleyici dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .istek_gecerli_i (istek_gecerli),
        .istek_hazir_o   (istek_hazir),
        .istek_kod_i     (istek_kod),
        .istek_islec1_i  (istek_islec1),
        .istek_islec2_i  (istek_islec2),
        .istek_rd_i      (istek_rd),
        .iptal_i         (iptal),
        .yzb_kod_o       (yzb_kod),
        .yzb_islec1_o    (yzb_islec1),
        .yzb_islec2_o    (yzb_islec2),
        .yzb_sonuc_i     (yzb_sonuc),
        .yzb_gecerli_i   (yzb_gecerli),
        .sonuc_o         (sonuc),
        .sonuc_rd_o      (sonuc_rd),
        .sonuc_gecerli_o (sonuc_gecerli),
        .sonuc_hazir_i   (sonuc_hazir),
        .hata_o          (hata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [2:0] k, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
        istek_gecerli = 1'b1;
        istek_kod     = k;
        istek_islec1  = a;
        istek_islec2  = b;
        istek_rd      = rd;
    endtask

    initial begin
        #12;
        check("rst_hazir", 32'(istek_hazir), 32'd1);
        check("rst_kod", 32'(yzb_kod), 32'(NOP));
        check("rst_islec1", yzb_islec1, 32'd0);
        check("rst_sonuc", sonuc, 32'd0);
        check("rst_gecerli", 32'(sonuc_gecerli), 32'd0);
        check("rst_hata", 32'(hata), 32'd0);
        rst = 1'b0;
        tick();

        // Loads then RUN
        req(LDX_ALL, 32'd3, 32'd4, 5'd0);
        tick();
        check("ldx_kod", 32'(yzb_kod), 32'(LDX_ALL));
        check("ldx_op1", yzb_islec1, 32'd3);
        check("ldx_op2", yzb_islec2, 32'd4);
        req(LDW_ALL, 32'd5, 32'd6, 5'd0);
        tick();
        check("ldw_kod", 32'(yzb_kod), 32'(LDW_ALL));
        check("ldw_op1", yzb_islec1, 32'd5);
        req(RUN, 32'd0, 32'd0, 5'd7);
        tick();
        check("run_kod", 32'(yzb_kod), 32'(RUN));
        check("run_hazir", 32'(istek_hazir), 32'd0);
        istek_gecerli = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wait_kod", 32'(yzb_kod), 32'(RUN));
            check("wait_hazir", 32'(istek_hazir), 32'd0);
            check("wait_gecerli", 32'(sonuc_gecerli), 32'd0);
        end
        yzb_gecerli = 1'b1;
        yzb_sonuc   = 32'd39;
        tick();
        yzb_gecerli = 1'b0;
        yzb_sonuc   = 32'd0;
        check("res_gecerli", 32'(sonuc_gecerli), 32'd1);
        check("res_sonuc", sonuc, 32'd39);
        check("res_rd", 32'(sonuc_rd), 32'd7);
        check("res_kod", 32'(yzb_kod), 32'(NOP));
        check("res_hazir", 32'(istek_hazir), 32'd0);

        // Backpressure in YAZ
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_sonuc", sonuc, 32'd39);
            check("bp_gecerli", 32'(sonuc_gecerli), 32'd1);
            check("bp_rd", 32'(sonuc_rd), 32'd7);
        end
        sonuc_hazir = 1'b1;
        req(CLRX, 32'd1, 32'd1, 5'd0);
        tick();
        check("rel_hazir", 32'(istek_hazir), 32'd1);
        check("rel_gecerli", 32'(sonuc_gecerli), 32'd0);
        check("rel_kod", 32'(yzb_kod), 32'(NOP));
        tick();
        check("clrx_kod", 32'(yzb_kod), 32'(CLRX));

        // Overflow of the X counter
        req(LDX_OP1, 32'd8, 32'd9, 5'd0);
        for (int i = 0; i < 15; i++) begin
            tick();
            check("fill_kod", 32'(yzb_kod), 32'(LDX_OP1));
            check("fill_hata", 32'(hata), 32'd0);
        end
        req(LDX_ALL, 32'd10, 32'd11, 5'd0);
        tick();
        check("ovf_kod", 32'(yzb_kod), 32'(NOP));
        check("ovf_hata", 32'(hata), 32'd1);
        check("ovf_op1", yzb_islec1, 32'd8);
        req(LDX_OP1, 32'd12, 32'd13, 5'd0);
        tick();
        check("last_kod", 32'(yzb_kod), 32'(LDX_OP1));
        check("last_hata", 32'(hata), 32'd0);
        tick();
        check("full_kod", 32'(yzb_kod), 32'(NOP));
        check("full_hata", 32'(hata), 32'd1);

        // Flush in BOSTA suppresses acceptance
        iptal = 1'b1;
        req(CLRW, 32'd0, 32'd0, 5'd0);
        tick();
        check("iptal_bosta_kod", 32'(yzb_kod), 32'(NOP));
        iptal = 1'b0;

        // Flush in CALISTIR, with a valid result arriving the same cycle
        req(RUN, 32'd0, 32'd0, 5'd3);
        tick();
        check("fl_run_kod", 32'(yzb_kod), 32'(RUN));
        istek_gecerli = 1'b0;
        iptal         = 1'b1;
        yzb_gecerli   = 1'b1;
        yzb_sonuc     = 32'd99;
        tick();
        iptal = 1'b0;
        check("fl_kod", 32'(yzb_kod), 32'(NOP));
        check("fl_gecerli", 32'(sonuc_gecerli), 32'd0);
        check("fl_hazir", 32'(istek_hazir), 32'd1);
        check("fl_sonuc", sonuc, 32'd39);

        // Spurious valid during loads, then immediate RUN result
        yzb_sonuc = 32'd0;
        req(LDW_OP1, 32'd2, 32'd2, 5'd0);
        tick();
        check("sp_kod", 32'(yzb_kod), 32'(LDW_OP1));
        check("sp_gecerli", 32'(sonuc_gecerli), 32'd0);
        check("sp_hazir", 32'(istek_hazir), 32'd1);
        req(CLRX, 32'd0, 32'd0, 5'd0);
        tick();
        check("sp_clrx", 32'(yzb_kod), 32'(CLRX));
        req(CLRW, 32'd0, 32'd0, 5'd0);
        tick();
        check("sp_clrw", 32'(yzb_kod), 32'(CLRW));
        req(RUN, 32'd0, 32'd0, 5'd9);
        tick();
        istek_gecerli = 1'b0;
        check("sp_run_kod", 32'(yzb_kod), 32'(RUN));
        check("sp_run_gecerli", 32'(sonuc_gecerli), 32'd0);
        tick();
        yzb_gecerli = 1'b0;
        check("sp_res_gecerli", 32'(sonuc_gecerli), 32'd1);
        check("sp_res_sonuc", sonuc, 32'd0);
        check("sp_res_rd", 32'(sonuc_rd), 32'd9);
        tick();
        check("sp_done_hazir", 32'(istek_hazir), 32'd1);

        // W counter was cleared: eight LDW_ALL fit, the ninth is dropped
        req(LDW_ALL, 32'd1, 32'd1, 5'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("wfill_kod", 32'(yzb_kod), 32'(LDW_ALL));
        end
        tick();
        check("wovf_kod", 32'(yzb_kod), 32'(NOP));
        check("wovf_hata", 32'(hata), 32'd1);

        // Asynchronous reset in the middle of CALISTIR
        req(RUN, 32'd11, 32'd12, 5'd5);
        tick();
        istek_gecerli = 1'b0;
        check("mr_kod", 32'(yzb_kod), 32'(RUN));
        #2 rst = 1'b1;
        #1;
        check("mr_kod0", 32'(yzb_kod), 32'(NOP));
        check("mr_hazir", 32'(istek_hazir), 32'd1);
        check("mr_islec1", yzb_islec1, 32'd0);
        check("mr_sonuc", sonuc, 32'd0);
        check("mr_rd", 32'(sonuc_rd), 32'd0);
        #2 rst = 1'b0;
        tick();
        check("mr_post_hazir", 32'(istek_hazir), 32'd1);
        check("mr_post_kod", 32'(yzb_kod), 32'(NOP));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
